// File: rtl/imem_program_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_program_loader.
// The slave modport is the loader; the master modport is whatever feeds the stream and consumes the writes.
interface imem_program_loader_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 13,
   parameter int BYTE_W = 8
);
   logic              i_start;
   logic [BYTE_W-1:0] i_byte;
   logic              i_byteValid;
   logic              o_byteReady;
   logic              o_imemWrite;
   logic [ADDR_W-1:0] o_imemAddr;
   logic [DATA_W-1:0] o_imemData;
   logic [ADDR_W:0]   o_count;
   logic              o_cpuHold;
   logic              o_done;
   logic              o_error;

   modport slave (
      input  i_start, i_byte, i_byteValid,
      output o_byteReady, o_imemWrite, o_imemAddr, o_imemData,
      output o_count, o_cpuHold, o_done, o_error
   );

   modport master (
      output i_start, i_byte, i_byteValid,
      input  o_byteReady, o_imemWrite, o_imemAddr, o_imemData,
      input  o_count, o_cpuHold, o_done, o_error
   );
endinterface

// File: rtl/imem_program_loader.sv
// Loads a framed program (N, N x {lo,hi}, XOR checksum) from a byte stream into instruction memory,
// holding the CPU until a load finishes with a good checksum.
module imem_program_loader #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 13,
   parameter int BYTE_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   imem_program_loader_if.slave  bus
);
   localparam int HI_W  = DATA_W - BYTE_W;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   typedef enum logic [2:0] {
      IDLE, COUNT, LO, HI, WR, CHK, DONE, ERROR
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   n_instr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic [BYTE_W-1:0] xsum;
   logic              byte_ready;
   logic              xfer;
   logic              start_load;

   assign byte_ready = (state == COUNT) || (state == LO) || (state == HI) || (state == CHK);
   assign xfer       = bus.i_byteValid && byte_ready;
   assign start_load = bus.i_start && ((state == IDLE) || (state == DONE) || (state == ERROR));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERROR: if (bus.i_start) state_nxt = COUNT;
         COUNT: if (xfer) begin
            if (bus.i_byte == '0 || bus.i_byte > BYTE_W'(DEPTH)) state_nxt = ERROR;
            else                                                 state_nxt = LO;
         end
         LO:  if (xfer) state_nxt = HI;
         // A high byte with anything above the instruction width aborts before the write slot.
         HI:  if (xfer) begin
            if (bus.i_byte[BYTE_W-1:HI_W] != '0) state_nxt = ERROR;
            else                                 state_nxt = WR;
         end
         WR:  state_nxt = ((count + CNT_ONE) == n_instr) ? CHK : LO;
         CHK: if (xfer) state_nxt = (bus.i_byte == xsum) ? DONE : ERROR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_instr <= '0;
         count   <= '0;
         addr    <= '0;
         data    <= '0;
         xsum    <= '0;
      end else begin
         if (start_load) begin
            count <= '0;
            addr  <= '0;
            xsum  <= '0;
         end
         if (xfer) xsum <= xsum ^ bus.i_byte;
         if (xfer && state == COUNT) n_instr <= bus.i_byte[ADDR_W:0];
         if (xfer && state == LO)    data[BYTE_W-1:0] <= bus.i_byte;
         if (xfer && state == HI)    data[DATA_W-1:BYTE_W] <= bus.i_byte[HI_W-1:0];
         // Address advances after the strobe cycle; a full 64-entry load wraps it back to 0.
         if (state == WR) begin
            addr  <= addr + ADDR_ONE;
            count <= count + CNT_ONE;
         end
      end
   end

   assign bus.o_byteReady = byte_ready;
   assign bus.o_imemWrite = (state == WR);
   assign bus.o_imemAddr  = addr;
   assign bus.o_imemData  = data;
   assign bus.o_count     = count;
   assign bus.o_cpuHold   = (state != DONE);
   assign bus.o_done      = (state == DONE);
   assign bus.o_error     = (state == ERROR);
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: good/bad frames, header and high-byte errors,
// a full 64-instruction load with stalls, and reset in the middle of a load.
module tb_imem_program_loader;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   int   wr_n = 0;
   int   base;
   logic [12:0] wr_data [0:127];
   logic [5:0]  wr_addr [0:127];
   logic [7:0]  x;

   imem_program_loader_if bus ();

   imem_program_loader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Strobe is high for a whole cycle, so the falling edge sees each write exactly once.
   always @(negedge clk) begin
      if (bus.o_imemWrite === 1'b1) begin
         if (wr_n < 128) begin
            wr_addr[wr_n] = bus.o_imemAddr;
            wr_data[wr_n] = bus.o_imemData;
         end
         wr_n = wr_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int w;
      if (gaps) begin
         bus.i_byteValid = 1'b0;
         repeat ($urandom_range(0, 2)) step();
      end
      bus.i_byte      = b;
      bus.i_byteValid = 1'b1;
      w = 0;
      while (bus.o_byteReady !== 1'b1 && w < 40) begin
         step();
         w++;
      end
      chk("ready_wait", 32'(w < 40), 32'd1);
      step();
      bus.i_byteValid = 1'b0;
   endtask

   initial begin
      reset           = 1'b0;
      bus.i_start     = 1'b0;
      bus.i_byte      = 8'h00;
      bus.i_byteValid = 1'b0;

      // 1: reset with random inputs
      repeat (4) begin
         bus.i_start     = 1'($urandom_range(0, 1));
         bus.i_byte      = 8'($urandom);
         bus.i_byteValid = 1'($urandom_range(0, 1));
         step();
      end
      chk("rst_hold",  32'(bus.o_cpuHold),   32'd1);
      chk("rst_ready", 32'(bus.o_byteReady), 32'd0);
      chk("rst_write", 32'(bus.o_imemWrite), 32'd0);
      chk("rst_done",  32'(bus.o_done),      32'd0);
      chk("rst_error", 32'(bus.o_error),     32'd0);
      chk("rst_count", 32'(bus.o_count),     32'd0);
      bus.i_start = 1'b0; bus.i_byteValid = 1'b0;
      reset = 1'b1;
      step(); step();
      chk("idle_hold",  32'(bus.o_cpuHold),   32'd1);
      chk("idle_ready", 32'(bus.o_byteReady), 32'd0);
      chk("idle_addr",  32'(bus.o_imemAddr),  32'd0);

      // 2: good two-instruction frame
      base = wr_n;
      pulse_start();
      chk("count_ready", 32'(bus.o_byteReady), 32'd1);
      send_byte(8'h02, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
      chk("wr_strobe", 32'(bus.o_imemWrite), 32'd1);
      chk("wr_addr0",  32'(bus.o_imemAddr),  32'd0);
      chk("wr_data0",  32'(bus.o_imemData),  32'h1234);
      chk("wr_ready",  32'(bus.o_byteReady), 32'd0);
      send_byte(8'hFF, 0); send_byte(8'h1F, 0); send_byte(8'hC4, 0);
      chk("g_nwr",   32'(wr_n - base),       32'd2);
      chk("g_a0",    32'(wr_addr[base]),     32'd0);
      chk("g_d0",    32'(wr_data[base]),     32'h1234);
      chk("g_a1",    32'(wr_addr[base+1]),   32'd1);
      chk("g_d1",    32'(wr_data[base+1]),   32'h1FFF);
      chk("g_count", 32'(bus.o_count),       32'd2);
      chk("g_done",  32'(bus.o_done),        32'd1);
      chk("g_hold",  32'(bus.o_cpuHold),     32'd0);
      chk("g_error", 32'(bus.o_error),       32'd0);

      // 3: bad checksum, then reload
      base = wr_n;
      pulse_start();
      chk("rl_done", 32'(bus.o_done),    32'd0);
      chk("rl_hold", 32'(bus.o_cpuHold), 32'd1);
      send_byte(8'h02, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
      send_byte(8'hFF, 0); send_byte(8'h1F, 0); send_byte(8'hC5, 0);
      chk("bc_nwr",   32'(wr_n - base),    32'd2);
      chk("bc_error", 32'(bus.o_error),    32'd1);
      chk("bc_hold",  32'(bus.o_cpuHold),  32'd1);
      chk("bc_done",  32'(bus.o_done),     32'd0);
      pulse_start();
      chk("bc_errclr", 32'(bus.o_error),   32'd0);
      send_byte(8'h02, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
      send_byte(8'hFF, 0); send_byte(8'h1F, 0); send_byte(8'hC4, 0);
      chk("bc_redone", 32'(bus.o_done),    32'd1);

      // 4: bad header counts and bad high byte
      base = wr_n;
      pulse_start();
      send_byte(8'h00, 0);
      chk("n00_error", 32'(bus.o_error), 32'd1);
      pulse_start();
      send_byte(8'h41, 0);
      chk("n41_error", 32'(bus.o_error), 32'd1);
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h34, 0); send_byte(8'h20, 0);
      chk("hi_error", 32'(bus.o_error),     32'd1);
      chk("hi_ready", 32'(bus.o_byteReady), 32'd0);
      step();
      chk("hdr_nwr",  32'(wr_n - base),     32'd0);

      // 5: full 64-instruction load with random stalls
      base = wr_n;
      x = 8'h40;
      pulse_start();
      send_byte(8'h40, 1);
      for (int i = 0; i < 64; i++) begin
         send_byte(8'(i), 1);
         send_byte(8'(i & 8'h1F), 1);
         x = x ^ 8'(i) ^ 8'(i & 8'h1F);
      end
      send_byte(x, 1);
      chk("f_nwr", 32'(wr_n - base), 32'd64);
      for (int i = 0; i < 64; i++) begin
         chk("f_addr", 32'(wr_addr[base+i]), 32'(i));
         chk("f_data", 32'(wr_data[base+i]), 32'({5'(i & 8'h1F), 8'(i)}));
      end
      chk("f_count", 32'(bus.o_count),    32'd64);
      chk("f_addr0", 32'(bus.o_imemAddr), 32'd0);
      chk("f_done",  32'(bus.o_done),     32'd1);

      // 6: ignored restart in LO, then reset during HI of the third instruction
      base = wr_n;
      pulse_start();
      send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h01, 0);
      step();
      pulse_start();
      chk("ig_count", 32'(bus.o_count),     32'd1);
      chk("ig_addr",  32'(bus.o_imemAddr),  32'd1);
      chk("ig_ready", 32'(bus.o_byteReady), 32'd1);
      send_byte(8'h22, 0); send_byte(8'h02, 0);
      step();
      send_byte(8'h33, 0);
      bus.i_byte      = 8'h03;
      bus.i_byteValid = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk("mr_write", 32'(bus.o_imemWrite), 32'd0);
      chk("mr_hold",  32'(bus.o_cpuHold),   32'd1);
      chk("mr_count", 32'(bus.o_count),     32'd0);
      chk("mr_ready", 32'(bus.o_byteReady), 32'd0);
      step(); step();
      reset = 1'b1;
      step(); step(); step();
      chk("mr_nwr",   32'(wr_n - base),        32'd2);
      chk("mr_d0",    32'(wr_data[base]),      32'h0111);
      chk("mr_a1",    32'(wr_addr[base+1]),    32'd1);
      chk("mr_d1",    32'(wr_data[base+1]),    32'h0222);
      chk("mr_idle",  32'(bus.o_byteReady),    32'd0);
      chk("mr_hold2", 32'(bus.o_cpuHold),      32'd1);
      bus.i_byteValid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
